// File: rtl/note_recorder.sv
// note_recorder: captures the key bus as run-length encoded {note, duration}
// entries while recording and replays them to the buzzer path.
//
// Ports:
//   i_clk          system clock
//   i_rst          synchronous active-high reset
//   i_rec_btn      record level; rising edge in IDLE starts, low ends
//   i_play_start   one-cycle pulse, starts playback from IDLE
//   i_pressed_key  key code (0 = rest)
//   i_key_pressed  key valid
//   o_note_to_play note being replayed
//   o_play_note    high while a non-rest entry is replayed
//   o_note_buzzed  pulse on the first cycle of each non-rest entry
//   o_play_done    pulse after the last entry has been replayed
//   o_rec_count    number of valid entries
//   o_full         buffer filled during the last recording
//   o_state        0 = IDLE, 1 = RECORD, 2 = PLAY
module note_recorder #(
  parameter int unsigned DEPTH   = 32,
  parameter int unsigned DUR_W   = 26,
  parameter int unsigned MAX_DUR = (1 << 26) - 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_rec_btn,
  input  logic                    i_play_start,
  input  logic [3:0]              i_pressed_key,
  input  logic                    i_key_pressed,
  output logic [3:0]              o_note_to_play,
  output logic                    o_play_note,
  output logic                    o_note_buzzed,
  output logic                    o_play_done,
  output logic [$clog2(DEPTH):0]  o_rec_count,
  output logic                    o_full,
  output logic [1:0]              o_state
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RECORD = 2'd1,
    S_PLAY   = 2'd2
  } state_t;

  typedef struct packed {
    logic [3:0]       note;
    logic [DUR_W-1:0] dur;
  } entry_t;

  // Entry buffer; never reset, validity is tracked by r_wr_ptr.
  entry_t r_mem [DEPTH];

  state_t           r_state;
  logic             r_rec_q;
  logic [CW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_rd_ptr;
  logic [DUR_W-1:0] r_cnt;
  logic [3:0]       r_seg_note;
  logic [DUR_W-1:0] r_seg_dur;
  logic             r_full;
  logic [3:0]       r_note_to_play;
  logic             r_play_note;
  logic             r_note_buzzed;
  logic             r_play_done;

  state_t           w_state_nxt;
  logic [CW-1:0]    w_wr_ptr_nxt;
  logic [CW-1:0]    w_rd_ptr_nxt;
  logic [DUR_W-1:0] w_cnt_nxt;
  logic [3:0]       w_seg_note_nxt;
  logic [DUR_W-1:0] w_seg_dur_nxt;
  logic             w_full_nxt;
  logic [3:0]       w_note_nxt;
  logic             w_play_note_nxt;
  logic             w_buzzed_nxt;
  logic             w_done_nxt;
  logic             w_wr_en;
  entry_t           w_wr_data;

  logic [3:0]       w_cur_note;
  logic             w_rec_rise;
  logic             w_last_slot;
  logic [AW-1:0]    w_wr_idx;
  logic [AW-1:0]    w_rd_idx;
  entry_t           w_rd_entry;

  assign w_cur_note  = i_key_pressed ? i_pressed_key : 4'd0;
  assign w_rec_rise  = i_rec_btn & ~r_rec_q;
  // The next write lands in the final slot and fills the buffer.
  assign w_last_slot = (r_wr_ptr == CW'(DEPTH - 1));
  assign w_wr_idx    = r_wr_ptr[AW-1:0];
  assign w_rd_idx    = r_rd_ptr[AW-1:0];
  assign w_rd_entry  = r_mem[w_rd_idx];

  // Next-state, datapath and next-output logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_wr_ptr_nxt    = r_wr_ptr;
    w_rd_ptr_nxt    = r_rd_ptr;
    w_cnt_nxt       = r_cnt;
    w_seg_note_nxt  = r_seg_note;
    w_seg_dur_nxt   = r_seg_dur;
    w_full_nxt      = r_full;
    w_note_nxt      = 4'd0;
    w_play_note_nxt = 1'b0;
    w_buzzed_nxt    = 1'b0;
    w_done_nxt      = 1'b0;
    w_wr_en         = 1'b0;
    w_wr_data       = '{note: r_seg_note, dur: r_seg_dur};

    case (r_state)
      S_IDLE: begin
        // Record start wins over a simultaneous play request.
        if (w_rec_rise) begin
          w_state_nxt    = S_RECORD;
          w_wr_ptr_nxt   = '0;
          w_full_nxt     = 1'b0;
          w_seg_note_nxt = w_cur_note;
          w_seg_dur_nxt  = DUR_W'(1);
        end else if (i_play_start && (r_wr_ptr != '0)) begin
          w_state_nxt  = S_PLAY;
          w_rd_ptr_nxt = '0;
          w_cnt_nxt    = '0;
        end
      end

      S_RECORD: begin
        if (!i_rec_btn) begin
          // Close out the open segment on release.
          w_wr_en      = 1'b1;
          w_wr_ptr_nxt = r_wr_ptr + CW'(1);
          w_state_nxt  = S_IDLE;
          if (w_last_slot) begin
            w_full_nxt = 1'b1;
          end
        end else if ((w_cur_note == r_seg_note) && (r_seg_dur < DUR_W'(MAX_DUR))) begin
          w_seg_dur_nxt = r_seg_dur + DUR_W'(1);
        end else begin
          // Note change or saturated run: commit and open a new segment.
          w_wr_en        = 1'b1;
          w_wr_ptr_nxt   = r_wr_ptr + CW'(1);
          w_seg_note_nxt = w_cur_note;
          w_seg_dur_nxt  = DUR_W'(1);
          if (w_last_slot) begin
            w_full_nxt  = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end

      S_PLAY: begin
        if (r_rd_ptr == r_wr_ptr) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_note_nxt      = w_rd_entry.note;
          w_play_note_nxt = (w_rd_entry.note != 4'd0);
          w_buzzed_nxt    = (r_cnt == '0) && (w_rd_entry.note != 4'd0);
          if (r_cnt == (w_rd_entry.dur - DUR_W'(1))) begin
            w_cnt_nxt    = '0;
            w_rd_ptr_nxt = r_rd_ptr + CW'(1);
          end else begin
            w_cnt_nxt = r_cnt + DUR_W'(1);
          end
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, control and output registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= S_IDLE;
      r_rec_q        <= 1'b0;
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_cnt          <= '0;
      r_seg_note     <= 4'd0;
      r_seg_dur      <= '0;
      r_full         <= 1'b0;
      r_note_to_play <= 4'd0;
      r_play_note    <= 1'b0;
      r_note_buzzed  <= 1'b0;
      r_play_done    <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_rec_q        <= i_rec_btn;
      r_wr_ptr       <= w_wr_ptr_nxt;
      r_rd_ptr       <= w_rd_ptr_nxt;
      r_cnt          <= w_cnt_nxt;
      r_seg_note     <= w_seg_note_nxt;
      r_seg_dur      <= w_seg_dur_nxt;
      r_full         <= w_full_nxt;
      r_note_to_play <= w_note_nxt;
      r_play_note    <= w_play_note_nxt;
      r_note_buzzed  <= w_buzzed_nxt;
      r_play_done    <= w_done_nxt;
    end
  end

  // Buffer write port.
  always_ff @(posedge i_clk) begin
    if (w_wr_en && !i_rst) begin
      r_mem[w_wr_idx] <= w_wr_data;
    end
  end

  assign o_note_to_play = r_note_to_play;
  assign o_play_note    = r_play_note;
  assign o_note_buzzed  = r_note_buzzed;
  assign o_play_done    = r_play_done;
  assign o_rec_count    = r_wr_ptr;
  assign o_full         = r_full;
  assign o_state        = r_state;

endmodule

// File: tb/tb_note_recorder.sv
// tb_note_recorder: directed and randomized record/playback scenarios for
// note_recorder, checked against a run-length model of the key stream.
module tb_note_recorder;

  localparam int unsigned DEPTH   = 8;
  localparam int unsigned DUR_W   = 26;
  localparam int unsigned MAX_DUR = 15;
  localparam int unsigned CW      = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          rec_btn;
  logic          play_start;
  logic [3:0]    pressed_key;
  logic          key_pressed;
  logic [3:0]    note_to_play;
  logic          play_note;
  logic          note_buzzed;
  logic          play_done;
  logic [CW-1:0] rec_count;
  logic          full;
  logic [1:0]    state;

  int n_assert = 0;
  int n_fail   = 0;

  // Stimulus: one {key_pressed, pressed_key} per recorded cycle.
  logic [4:0] stim_q [$];
  // Model: expected buffer contents for the last completed recording.
  int exp_note [$];
  int exp_dur  [$];
  int g_total;

  note_recorder #(.DEPTH(DEPTH), .DUR_W(DUR_W), .MAX_DUR(MAX_DUR)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_rec_btn      (rec_btn),
    .i_play_start   (play_start),
    .i_pressed_key  (pressed_key),
    .i_key_pressed  (key_pressed),
    .o_note_to_play (note_to_play),
    .o_play_note    (play_note),
    .o_note_buzzed  (note_buzzed),
    .o_play_done    (play_done),
    .o_rec_count    (rec_count),
    .o_full         (full),
    .o_state        (state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int cur_of(input logic [4:0] s);
    return s[4] ? int'(s[3:0]) : 0;
  endfunction

  // Split the sampled stream into maximal runs, then cut each run into
  // MAX_DUR-sized chunks; g_total counts every chunk, written or not.
  task automatic build_model();
    int i;
    int run_note;
    int run_len;
    int d;
    exp_note.delete();
    exp_dur.delete();
    i = 0;
    while (i < stim_q.size()) begin
      run_note = cur_of(stim_q[i]);
      run_len  = 0;
      while ((i < stim_q.size()) && (cur_of(stim_q[i]) == run_note)) begin
        run_len++;
        i++;
      end
      while (run_len > 0) begin
        d = (run_len > int'(MAX_DUR)) ? int'(MAX_DUR) : run_len;
        exp_note.push_back(run_note);
        exp_dur.push_back(d);
        run_len -= d;
      end
    end
    g_total = exp_note.size();
  endtask

  function automatic logic [4:0] enc(input int note);
    logic [4:0] s;
    if (note == 0) begin
      if ($urandom_range(0, 1) == 0) s = {1'b0, 4'($urandom_range(0, 15))};
      else                           s = 5'b1_0000;
    end else begin
      s = {1'b1, 4'(note)};
    end
    return s;
  endfunction

  task automatic add_run(input int note, input int len);
    for (int k = 0; k < len; k++) stim_q.push_back(enc(note));
  endtask

  // Record stim_q; poke adds a play_start on the starting edge and mid-record.
  task automatic do_record(input bit poke);
    int pre;
    int post;
    build_model();
    for (int i = 0; i < stim_q.size(); i++) begin
      rec_btn     = 1'b1;
      key_pressed = stim_q[i][4];
      pressed_key = stim_q[i][3:0];
      play_start  = poke && ((i == 0) || (i == 2));
      step();
      if (i == 0) begin
        chk("rec_start_state", 32'(state), 32'(1));
        chk("rec_start_count", 32'(rec_count), 32'(0));
        chk("rec_start_full", 32'(full), 32'(0));
        chk("rec_start_play_note", 32'(play_note), 32'(0));
      end
    end
    play_start = 1'b0;
    pre = ((g_total - 1) < int'(DEPTH)) ? (g_total - 1) : int'(DEPTH);
    chk("pre_release_count", 32'(rec_count), pre);
    chk("pre_release_state", 32'(state), ((g_total - 1) >= int'(DEPTH)) ? 32'(0) : 32'(1));
    chk("pre_release_full", 32'(full), 32'((g_total - 1) >= int'(DEPTH)));
    rec_btn     = 1'b0;
    key_pressed = 1'b0;
    pressed_key = 4'd0;
    step();
    post = (g_total < int'(DEPTH)) ? g_total : int'(DEPTH);
    chk("post_release_count", 32'(rec_count), post);
    chk("post_release_full", 32'(full), 32'(g_total >= int'(DEPTH)));
    chk("post_release_state", 32'(state), 32'(0));
  endtask

  // Replay and compare against the expanded entry list; abort_at >= 0 fires
  // reset after that trace cycle; poke raises rec_btn/play_start mid-play.
  task automatic do_play(input bit poke, input int abort_at);
    int tr_note [$];
    int tr_buzz [$];
    int n_ent;
    n_ent = (g_total < int'(DEPTH)) ? g_total : int'(DEPTH);
    for (int e = 0; e < n_ent; e++) begin
      for (int c = 0; c < exp_dur[e]; c++) begin
        tr_note.push_back(exp_note[e]);
        tr_buzz.push_back(((c == 0) && (exp_note[e] != 0)) ? 1 : 0);
      end
    end
    play_start = 1'b1;
    step();
    play_start = 1'b0;
    chk("play_enter_state", 32'(state), 32'(2));
    chk("play_enter_note", 32'(note_to_play), 32'(0));
    for (int j = 0; j < tr_note.size(); j++) begin
      step();
      chk("play_note_val", 32'(note_to_play), tr_note[j]);
      chk("play_note_flag", 32'(play_note), 32'(tr_note[j] != 0));
      chk("play_buzz", 32'(note_buzzed), tr_buzz[j]);
      chk("play_done_low", 32'(play_done), 32'(0));
      if (j == abort_at) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_note", 32'(note_to_play), 32'(0));
        chk("abort_play_note", 32'(play_note), 32'(0));
        chk("abort_buzz", 32'(note_buzzed), 32'(0));
        chk("abort_done", 32'(play_done), 32'(0));
        chk("abort_count", 32'(rec_count), 32'(0));
        chk("abort_full", 32'(full), 32'(0));
        chk("abort_state", 32'(state), 32'(0));
        return;
      end
      if (poke) begin
        if (j == 1) begin rec_btn = 1'b1; play_start = 1'b1; end
        if (j == 2) play_start = 1'b0;
        if (j == 3) rec_btn = 1'b0;
      end
    end
    rec_btn    = 1'b0;
    play_start = 1'b0;
    step();
    chk("done_pulse", 32'(play_done), 32'(1));
    chk("done_state", 32'(state), 32'(0));
    chk("done_note", 32'(note_to_play), 32'(0));
    chk("done_play_note", 32'(play_note), 32'(0));
    step();
    chk("done_cleared", 32'(play_done), 32'(0));
    chk("done_idle", 32'(state), 32'(0));
  endtask

  initial begin
    rst         = 1'b1;
    rec_btn     = 1'b0;
    play_start  = 1'b0;
    pressed_key = 4'd0;
    key_pressed = 1'b0;
    step();
    step();
    rst = 1'b0;

    // Reset state
    chk("rst_state", 32'(state), 32'(0));
    chk("rst_count", 32'(rec_count), 32'(0));
    chk("rst_full", 32'(full), 32'(0));
    chk("rst_note", 32'(note_to_play), 32'(0));
    chk("rst_done", 32'(play_done), 32'(0));

    // Play request with an empty buffer is ignored
    play_start = 1'b1;
    step();
    play_start = 1'b0;
    chk("empty_play_state", 32'(state), 32'(0));
    chk("empty_play_note", 32'(play_note), 32'(0));
    step();
    chk("empty_play_done", 32'(play_done), 32'(0));
    chk("empty_play_state2", 32'(state), 32'(0));

    // Three-entry phrase with a rest in the middle
    stim_q.delete();
    add_run(3, 5);
    add_run(0, 2);
    add_run(5, 4);
    do_record(1'b0);
    chk("phrase_entries", 32'(rec_count), 32'(3));
    do_play(1'b0, -1);

    // Long hold splits at the saturation limit
    stim_q.delete();
    add_run(7, 40);
    do_record(1'b0);
    chk("hold_entries", 32'(rec_count), 32'(3));
    do_play(1'b0, -1);

    // Alternating keys fill the buffer while rec_btn is still held
    stim_q.delete();
    for (int k = 0; k < 12; k++) add_run((k % 2 == 0) ? 1 : 2, 1);
    do_record(1'b0);
    do_play(1'b0, -1);

    // Ignored controls during record/play; rec+play in one IDLE cycle records
    stim_q.delete();
    add_run(4, 3);
    add_run(9, 2);
    add_run(0, 1);
    add_run(2, 3);
    do_record(1'b1);
    do_play(1'b1, -1);

    // Randomized recordings
    for (int r = 0; r < 8; r++) begin
      int nruns;
      stim_q.delete();
      nruns = int'($urandom_range(1, 9));
      for (int k = 0; k < nruns; k++) begin
        add_run(int'($urandom_range(0, 15)), int'($urandom_range(1, 34)));
      end
      do_record(($urandom_range(0, 1) == 1) && (rec_count != '0));
      do_play($urandom_range(0, 1) == 1, -1);
    end

    // Reset during playback of entry 1 discards the recording
    stim_q.delete();
    add_run(6, 3);
    add_run(8, 4);
    add_run(0, 2);
    do_record(1'b0);
    do_play(1'b0, 4);
    play_start = 1'b1;
    step();
    play_start = 1'b0;
    chk("post_abort_play_state", 32'(state), 32'(0));
    step();
    chk("post_abort_no_done", 32'(play_done), 32'(0));
    chk("post_abort_note", 32'(note_to_play), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
